pc_jump_ctrl: RTL and testbench

// - Next-PC sequencer for the RV32I core; owns the PC register and steers the mux_Jalr select.
// - Resolves JAL, JALR and taken branches, redirects the PC and generates the link value (PC+4).
// - Issues a fixed-length pipeline flush after every redirect.
// - Sits between decode/branch-compare and instruction fetch.

---
 rtl/pc_jump_if.sv | 29 ++
 rtl/pc_jump_ctrl.sv | 148 ++++++++++++++
 tb/tb_pc_jump_ctrl.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/pc_jump_if.sv
// pc_jump_if: request/response bundle between decode and the next-PC sequencer.
// The master drives the strobes and operands; the slave returns PC, link and control.
interface pc_jump_if;
    logic        stall;
    logic        jal;
    logic        jalr;
    logic        branch;
    logic        branch_taken;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic        trap_clr;
    logic [31:0] pc;
    logic [31:0] link;
    logic        sel_jalr;
    logic        flush;
    logic        misalign;

    modport master (
        output stall, jal, jalr, branch, branch_taken,
        output imm, rs1, trap_clr,
        input  pc, link, sel_jalr, flush, misalign
    );

    modport slave (
        input  stall, jal, jalr, branch, branch_taken,
        input  imm, rs1, trap_clr,
        output pc, link, sel_jalr, flush, misalign
    );
endinterface

// File: rtl/pc_jump_ctrl.sv
// pc_jump_ctrl: next-PC sequencer with JAL/JALR/branch redirect and post-redirect flush.
// Optional MISALIGN_TRAP_EN: misaligned targets trap instead of being truncated.
module pc_jump_ctrl #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input logic      clk,
    input logic      rst_n,
    pc_jump_if.slave bus
);
    localparam logic [1:0] S_RUN   = 2'd0;
    localparam logic [1:0] S_FLUSH = 2'd1;
`ifdef MISALIGN_TRAP_EN
    localparam logic [1:0] S_TRAP  = 2'd2;
`endif

    logic [31:0] pc_q, pc_d;
    logic [31:0] link_q, link_d;
    logic        sel_jalr_q, sel_jalr_d;
    logic        flush_q, flush_d;
    logic [1:0]  state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        req;
    logic        is_jump;
    logic        bad;
    logic [31:0] tgt_raw;
    logic [31:0] target;
`ifdef MISALIGN_TRAP_EN
    logic        misalign_q, misalign_d;
`endif

    // Resolve the winning request and its target address
    always_comb begin
        is_jump = bus.jalr | bus.jal;
        req     = is_jump | (bus.branch & bus.branch_taken);
        if (bus.jalr) begin
            tgt_raw = (bus.rs1 + bus.imm) & ~32'h1;
        end else begin
            tgt_raw = pc_q + bus.imm;
        end
`ifdef MISALIGN_TRAP_EN
        target = tgt_raw;
        bad    = tgt_raw[1];
`else
        target = tgt_raw & ~32'h3;
        bad    = 1'b0;
`endif
    end

    // Next-state logic for PC, link, FSM and flush counter
    always_comb begin
        pc_d       = pc_q;
        link_d     = link_q;
        sel_jalr_d = 1'b0;
        state_d    = state_q;
        cnt_d      = cnt_q;
        if (bus.stall) begin
`ifdef MISALIGN_TRAP_EN
            if (state_q == S_TRAP && bus.trap_clr) begin
                state_d = S_RUN;
                pc_d    = RESET_PC;
            end
`endif
        end else begin
            unique case (state_q)
                S_RUN: begin
                    if (req && bad) begin
`ifdef MISALIGN_TRAP_EN
                        state_d = S_TRAP;
`endif
                    end else if (req) begin
                        pc_d    = target;
                        state_d = S_FLUSH;
                        cnt_d   = 3'(FLUSH_CYCLES);
                        if (is_jump) begin
                            link_d     = pc_q + 32'd4;
                            sel_jalr_d = 1'b1;
                        end
                    end else begin
                        pc_d = pc_q + 32'd4;
                    end
                end
                S_FLUSH: begin
                    pc_d  = pc_q + 32'd4;
                    cnt_d = cnt_q - 3'd1;
                    if (cnt_q <= 3'd1) begin
                        cnt_d   = 3'd0;
                        state_d = S_RUN;
                    end
                end
`ifdef MISALIGN_TRAP_EN
                S_TRAP: begin
                    if (bus.trap_clr) begin
                        state_d = S_RUN;
                        pc_d    = RESET_PC;
                    end
                end
`endif
                default: begin
                    state_d = S_RUN;
                    cnt_d   = 3'd0;
                end
            endcase
        end
        flush_d = (state_d != S_RUN);
`ifdef MISALIGN_TRAP_EN
        misalign_d = (state_d == S_TRAP);
`endif
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            link_q     <= 32'd0;
            sel_jalr_q <= 1'b0;
            flush_q    <= 1'b0;
            state_q    <= S_RUN;
            cnt_q      <= 3'd0;
        end else begin
            pc_q       <= pc_d;
            link_q     <= link_d;
            sel_jalr_q <= sel_jalr_d;
            flush_q    <= flush_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
        end
    end

`ifdef MISALIGN_TRAP_EN
    // Misalign flag register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end
    assign bus.misalign = misalign_q;
`else
    assign bus.misalign = 1'b0;
`endif

    assign bus.pc       = pc_q;
    assign bus.link     = link_q;
    assign bus.sel_jalr = sel_jalr_q;
    assign bus.flush    = flush_q;
endmodule

// File: tb/tb_pc_jump_ctrl.sv
// tb_pc_jump_ctrl: directed stimulus with a scoreboard queue and
// an independent monitor comparing the registered outputs every cycle.
module tb_pc_jump_ctrl;
    logic clk;
    logic rst_n;
    pc_jump_if bus ();

    pc_jump_ctrl #(
        .RESET_PC    (32'h0000_0000),
        .FLUSH_CYCLES(2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] link;
        logic        sel;
        logic        fl;
        logic        mis;
    } exp_t;

    exp_t sb[$];
    int   checks;
    int   failures;
    int   row;
    logic stim_done;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s row=%0d actual=%h required=%h",
                     nm, row, act, req);
        end
    endtask

    task automatic chk_all(input exp_t e);
        chk("pc", bus.pc, e.pc);
        chk("link", bus.link, e.link);
        chk("sel_jalr", {31'd0, bus.sel_jalr}, {31'd0, e.sel});
        chk("flush", {31'd0, bus.flush}, {31'd0, e.fl});
        chk("misalign", {31'd0, bus.misalign}, {31'd0, e.mis});
    endtask

    // Monitor: one expectation per clock edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk_all(e);
                row++;
            end
        end
    end

    task automatic cyc(input logic st, input logic j, input logic jr,
                       input logic br, input logic bt,
                       input logic [31:0] im, input logic [31:0] r1,
                       input logic clr,
                       input logic [31:0] e_pc, input logic [31:0] e_lk,
                       input logic e_sel, input logic e_fl,
                       input logic e_mis);
        exp_t e;
        @(negedge clk);
        bus.stall        = st;
        bus.jal          = j;
        bus.jalr         = jr;
        bus.branch       = br;
        bus.branch_taken = bt;
        bus.imm          = im;
        bus.rs1          = r1;
        bus.trap_clr     = clr;
        e.pc   = e_pc;
        e.link = e_lk;
        e.sel  = e_sel;
        e.fl   = e_fl;
        e.mis  = e_mis;
        sb.push_back(e);
    endtask

    task automatic idle(input logic [31:0] e_pc, input logic [31:0] e_lk,
                        input logic e_fl);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, e_pc, e_lk, 0, e_fl, 0);
    endtask

    logic [31:0] p27;
    logic [31:0] l27;

    // Stimulus
    initial begin
        exp_t z;
        int   n;
        checks    = 0;
        failures  = 0;
        row       = 0;
        stim_done = 1'b0;
        rst_n     = 1'b0;
        bus.stall = 0; bus.jal = 0; bus.jalr = 0; bus.branch = 0;
        bus.branch_taken = 0; bus.imm = 0; bus.rs1 = 0; bus.trap_clr = 0;
        z = '{32'h0, 32'h0, 1'b0, 1'b0, 1'b0};

        idle(32'h0, 32'h0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        sb.push_back('{32'h4, 32'h0, 1'b0, 1'b0, 1'b0});
        idle(32'h8, 0, 0);
        idle(32'hC, 0, 0);
        idle(32'h10, 0, 0);
        cyc(0, 1, 0, 0, 0, 32'hE8, 0, 0, 32'hF8, 32'h14, 1, 1, 0);
        idle(32'hFC, 32'h14, 1);
        idle(32'h100, 32'h14, 0);
        cyc(0, 1, 0, 0, 0, 32'h40, 0, 0, 32'h140, 32'h104, 1, 1, 0);
        idle(32'h144, 32'h104, 1);
        idle(32'h148, 32'h104, 0);
        idle(32'h14C, 32'h104, 0);
        cyc(0, 0, 0, 1, 1, 32'h10, 0, 0, 32'h15C, 32'h104, 0, 1, 0);
        cyc(0, 1, 0, 0, 0, 32'h1000, 0, 0, 32'h160, 32'h104, 0, 1, 0);
        idle(32'h164, 32'h104, 0);
        cyc(0, 0, 0, 1, 0, 32'h100, 0, 0, 32'h168, 32'h104, 0, 0, 0);
        cyc(0, 1, 1, 1, 1, 32'h10, 32'h2001, 0,
            32'h2010, 32'h16C, 1, 1, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 32'h2010, 32'h16C, 0, 1, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 32'h2010, 32'h16C, 0, 1, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 32'h2010, 32'h16C, 0, 1, 0);
        idle(32'h2014, 32'h16C, 1);
        idle(32'h2018, 32'h16C, 0);
        cyc(1, 1, 0, 0, 0, 32'h80, 0, 0, 32'h2018, 32'h16C, 0, 0, 0);
        idle(32'h201C, 32'h16C, 0);
`ifdef MISALIGN_TRAP_EN
        cyc(0, 0, 1, 0, 0, 32'h2, 32'h2000, 0,
            32'h201C, 32'h16C, 0, 1, 1);
        cyc(0, 1, 0, 0, 0, 32'h40, 0, 0, 32'h201C, 32'h16C, 0, 1, 1);
        cyc(1, 0, 0, 0, 0, 0, 0, 1, 32'h0, 32'h16C, 0, 0, 0);
        idle(32'h4, 32'h16C, 0);
        p27 = 32'h4;
        l27 = 32'h16C;
`else
        cyc(0, 0, 1, 0, 0, 32'h2, 32'h2000, 0,
            32'h2000, 32'h2020, 1, 1, 0);
        idle(32'h2004, 32'h2020, 1);
        idle(32'h2008, 32'h2020, 0);
        idle(32'h200C, 32'h2020, 0);
        p27 = 32'h200C;
        l27 = 32'h2020;
`endif
        cyc(0, 0, 1, 0, 0, 0, 32'h3000, 0,
            32'h3000, p27 + 32'd4, 1, 1, 0);
        @(negedge clk);
        bus.jalr = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk_all(z);
        sb.push_back(z);
        @(negedge clk);
        rst_n = 1'b1;
        sb.push_back('{32'h4, 32'h0, 1'b0, 1'b0, 1'b0});
        idle(32'h8, 0, 0);
        cyc(0, 0, 1, 0, 0, 0, 32'hFFFF_FFF4, 0,
            32'hFFFF_FFF4, 32'hC, 1, 1, 0);
        idle(32'hFFFF_FFF8, 32'hC, 1);
        idle(32'hFFFF_FFFC, 32'hC, 0);
        idle(32'h0, 32'hC, 0);
        n = 0;
        while (sb.size() > 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        #2;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain actual=%0d required=0", sb.size());
        end
        if (l27 == 32'hx) failures++;
        stim_done = 1'b1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
